fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the decode stage. Owns the PC register, drives the instruction-memory address, and holds the IF/ID pipeline register that supplies `D_ins`/`D_PC` to decode. Accepts branch/jump redirects (`DnPC` and `PCw_enable`) from decode, and stall requests from the hazard unit. Absorbs a variable-latency instruction memory via a valid signal and a three-state FSM.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value after reset.
- `NOP_INS`, default 32'h0000_0000: bubble instruction loaded into IF/ID.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `stall`  in  1: hazard-unit stall; freezes PC, IF/ID, FSM and pending redirect.
- `redirect_en`  in  1: decode's `PCw_enable`; taken branch/jump. Sampled only when `stall`=0.
- `redirect_pc`  in  32: decode's `DnPC`; target address. Bits [1:0] are ignored.
- `imem_addr`  out  32: equals `F_PC` (combinational).
- `imem_rdata`  in  32: instruction word at `imem_addr`.
- `imem_valid`  in  1: `imem_rdata` is valid this cycle.
- `F_PC`  out  32: current fetch PC.
- `D_ins`  out  32: IF/ID instruction.
- `D_PC`  out  32: IF/ID PC.
- `D_valid`  out  1: IF/ID holds a real instruction rather than a bubble.

## Operation
- **Fetch completes** when `imem_valid`=1 and `stall`=0. IF/ID then loads {`imem_rdata`, `F_PC`, 1}.
- **Next PC** = pending target if one exists, else live accepted redirect, else `F_PC`+4 (mod 2^32).
- **FSM states:**
  - RUN: no outstanding miss.
  - WAIT: miss outstanding, no pending redirect.
  - WAIT_R: miss outstanding, redirect captured in `pend_pc`.
- **Transitions (`stall`=0):**
  - RUN, `imem_valid`=1: stay RUN; fetch completes.
  - RUN, `imem_valid`=0, `redirect_en`=0: go to WAIT. IF/ID loads bubble {`NOP_INS`, `F_PC`, 0}; PC holds.
  - RUN/WAIT, `imem_valid`=0, `redirect_en`=1: capture `pend_pc`=`redirect_pc`; go to WAIT_R; bubble.
  - WAIT, `imem_valid`=1: fetch completes; go to RUN.
  - WAIT_R, `imem_valid`=1: fetch completes; PC <= `pend_pc`; pending cleared; go to RUN.
  - WAIT_R, further `redirect_en`: ignored. Decode is holding bubbles and cannot issue a new one.
- **`stall`=1 overrides everything except reset:** PC, IF/ID, state and `pend_pc` hold; `redirect_en` and `imem_valid` are ignored.
- **Reset (any time, including mid-miss):**
  - PC = `RESET_PC`, state RUN, pending cleared.
  - IF/ID = {`NOP_INS`, `RESET_PC`, 0}.
  - Memory responses for the abandoned address are discarded.
- PC bits [1:0] are always 0.

## Timing
- Fetch-to-decode latency: 1 cycle after completion (`D_ins` is valid the cycle after `imem_valid`).
- Zero-wait memory gives one instruction per cycle.
- `imem_addr` changes only on clock edges. The memory must keep `imem_valid`/`imem_rdata` tied to the address presented in the same cycle.
- Redirect is taken on the edge of the accepting cycle: in RUN with a hit, the target appears on `F_PC` next cycle.
- **Reset values:** `F_PC`=`imem_addr`=`RESET_PC`; `D_ins`=`NOP_INS`; `D_PC`=`RESET_PC`; `D_valid`=0.

## Configuration
- **`FETCH_DELAY_SLOT_EN` defined:** MIPS branch delay slot. The instruction being fetched when the redirect is accepted is kept in IF/ID. The redirect applies after that fetch completes, per the FSM above.
- **Macro undefined:** no delay slot.
  - An accepted redirect immediately loads a bubble into IF/ID.
  - PC <= `redirect_pc` and the state goes to RUN, regardless of `imem_valid`.
  - WAIT_R is unreachable; `pend_pc` logic is compiled out.

## Structure
- Shared package/header holds `RESET_PC` default, `NOP_INS`, and the FSM state encoding (RUN=2'd0, WAIT=2'd1, WAIT_R=2'd2).
- One sub-module, `if_id_reg`: holds {ins, pc, valid}, with inputs `en` (load), `bubble`, async reset. `fetch_stage` instantiates it.
- PC register, FSM and pending register live in `fetch_stage`.

## Test plan
- **Reset then zero-wait memory, 3 cycles:** `F_PC` = 3000, 3004, 3008, 300C; `D_PC` lags by 1 cycle; `D_valid`=1 from cycle 1.
- **`stall`=1 for 2 cycles at `F_PC`=3008:** `F_PC`, `D_ins`, `D_PC` unchanged; resumes at 300C.
- **Redirect in RUN with a hit, `redirect_pc`=3100 while fetching 3008:**
  - Macro defined: `D_PC`=3008, then `F_PC`=3100.
  - Macro undefined: `D_valid`=0, `F_PC`=3100.
- **Redirect to 3200 during a 2-cycle miss at 300C (macro defined):**
  - State goes to WAIT_R; bubbles with `D_valid`=0.
  - On hit: `D_PC`=300C, then `F_PC`=3200.
- **`redirect_pc`=32'h0000_3103:** `F_PC`=3100.
- **Reset asserted mid-miss in WAIT_R:** all outputs return to reset values immediately; pending redirect not applied afterwards.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: reset PC, bubble
// instruction and the miss-handling FSM encoding.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_INS_DEFAULT  = 32'h0000_0000;

    // RUN: no outstanding miss; WAIT: miss outstanding;
    // WAIT_R: miss outstanding with a redirect held in pend_pc.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        WAIT   = 2'd1,
        WAIT_R = 2'd2
    } fetch_state_t;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Signal bundle between the fetch stage and its neighbours: hazard unit
// stall, decode redirect, instruction memory port and the IF/ID outputs.
// The slave modport is the fetch stage's view, master is the environment's.
interface fetch_if;
    logic        stall;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] f_pc;
    logic [31:0] d_ins;
    logic [31:0] d_pc;
    logic        d_valid;

    modport slave (
        input  stall, redirect_en, redirect_pc, imem_rdata, imem_valid,
        output imem_addr, f_pc, d_ins, d_pc, d_valid
    );

    modport master (
        output stall, redirect_en, redirect_pc, imem_rdata, imem_valid,
        input  imem_addr, f_pc, d_ins, d_pc, d_valid
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. When enabled it captures either the fetched
// instruction (valid) or a bubble carrying the current PC (not valid).
module if_id_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] NOP_INS  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        bubble,
    input  logic [31:0] ins,
    input  logic [31:0] pc,
    output logic [31:0] q_ins,
    output logic [31:0] q_pc,
    output logic        q_valid
);

    // Load instruction or bubble on enable; hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_ins   <= NOP_INS;
            q_pc    <= RESET_PC;
            q_valid <= 1'b0;
        end else if (en) begin
            q_ins   <= bubble ? NOP_INS : ins;
            q_pc    <= pc;
            q_valid <= ~bubble;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, miss-handling FSM and IF/ID register.
// Optional feature macro: FETCH_DELAY_SLOT_EN (MIPS branch delay slot).
// Without it a redirect bubbles IF/ID and jumps at once; with it the
// in-flight fetch completes first and a redirect during a miss is parked
// in pend_pc until the memory answers.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INS  = NOP_INS_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    fetch_if.slave bus
);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic [31:0]  pc_plus4;
    logic [31:0]  target;
    logic         if_en;
    logic         if_bubble;

    assign pc_plus4      = pc + 32'd4;
    assign target        = word_align(bus.redirect_pc);
    assign bus.imem_addr = pc;
    assign bus.f_pc      = pc;

`ifdef FETCH_DELAY_SLOT_EN
    logic [31:0] pend_pc;
    logic        pend_load;

    // Park a redirect that arrives while a miss is outstanding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_pc <= RESET_PC;
        end else if (pend_load) begin
            pend_pc <= target;
        end
    end
`endif

    // State and PC registers; stall is folded into the next-value logic.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Next-state logic for the miss FSM.
    // NOTE: each combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        if (!bus.stall) begin
`ifdef FETCH_DELAY_SLOT_EN
            unique case (state)
                RUN, WAIT: begin
                    if (bus.imem_valid)       state_next = RUN;
                    else if (bus.redirect_en) state_next = WAIT_R;
                    else                      state_next = WAIT;
                end
                WAIT_R: begin
                    if (bus.imem_valid)       state_next = RUN;
                end
                default:                      state_next = RUN;
            endcase
`else
            unique case (state)
                RUN, WAIT: begin
                    if (bus.redirect_en || bus.imem_valid) state_next = RUN;
                    else                                   state_next = WAIT;
                end
                default:                                   state_next = RUN;
            endcase
`endif
        end
    end

    // FSM outputs: next PC, IF/ID load/bubble control, pending capture.
    always_comb begin
        pc_next   = pc;
        if_en     = 1'b0;
        if_bubble = 1'b0;
`ifdef FETCH_DELAY_SLOT_EN
        pend_load = 1'b0;
`endif
        if (!bus.stall) begin
            if_en     = 1'b1;
            if_bubble = ~bus.imem_valid;
`ifdef FETCH_DELAY_SLOT_EN
            if (bus.imem_valid) begin
                if (state == WAIT_R)      pc_next = pend_pc;
                else if (bus.redirect_en) pc_next = target;
                else                      pc_next = pc_plus4;
            end else if (bus.redirect_en && state != WAIT_R) begin
                // Decode cannot redirect again while WAIT_R is bubbling it.
                pend_load = 1'b1;
            end
`else
            if (bus.redirect_en) begin
                if_bubble = 1'b1;
                pc_next   = target;
            end else if (bus.imem_valid) begin
                pc_next   = pc_plus4;
            end
`endif
        end
    end

    if_id_reg #(
        .RESET_PC (RESET_PC),
        .NOP_INS  (NOP_INS)
    ) u_if_id (
        .clk     (clk),
        .reset   (reset),
        .en      (if_en),
        .bubble  (if_bubble),
        .ins     (bus.imem_rdata),
        .pc      (pc),
        .q_ins   (bus.d_ins),
        .q_pc    (bus.d_pc),
        .q_valid (bus.d_valid)
    );

endmodule
